// File: rtl/video_pattern_gen.sv
// Raster timing and test-pattern generator: bars (with optional scroll), checker,
// gradient and solid colour. Pattern controls are latched once per frame.
module video_pattern_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int PIX_SZ      = 8,
    parameter int CHK_LOG2    = 5,
    parameter int SCROLL_STEP = 1
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_i,
    input  logic [1:0]                                            mode_i,
    input  logic                                                  scroll_en_i,
    input  logic [3*PIX_SZ-1:0]                                   solid_rgb_i,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]          hcount_o,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]          vcount_o,
    output logic                                                  de_o,
    output logic                                                  hsync_o,
    output logic                                                  vsync_o,
    output logic                                                  frame_start_o,
    output logic [PIX_SZ-1:0]                                     r_o,
    output logic [PIX_SZ-1:0]                                     g_o,
    output logic [PIX_SZ-1:0]                                     b_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int XW      = $clog2(H_ACTIVE + SCROLL_STEP + 1);
    localparam int RW      = $clog2(BAR_W + SCROLL_STEP + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [XW-1:0] X_ACT      = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_LAST     = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] X_STEP     = XW'(SCROLL_STEP);
    localparam logic [RW-1:0] R_BAR      = RW'(BAR_W);
    localparam logic [RW-1:0] R_LAST     = RW'(BAR_W - 1);
    localparam logic [RW-1:0] R_STEP     = RW'(SCROLL_STEP);
    localparam logic          HS_ON      = 1'(HS_POL);
    localparam logic          VS_ON      = 1'(VS_POL);

    // Position currently being computed; it appears on the outputs one edge later.
    logic [HW-1:0]         h_pos;
    logic [VW-1:0]         v_pos;
    logic [1:0]            mode_q;
    logic [3*PIX_SZ-1:0]   solid_q;

    // Scroll offset is kept as (offset, offset / BAR_W, offset mod BAR_W) so no divider is needed.
    logic [XW-1:0]         off_q;
    logic [2:0]            off_idx_q;
    logic [RW-1:0]         off_rem_q;
    logic [XW-1:0]         x_q;
    logic [2:0]            idx_q;
    logic [RW-1:0]         rem_q;

    logic                  frame_first;
    logic [1:0]            mode_cur;
    logic [3*PIX_SZ-1:0]   solid_cur;
    logic [XW-1:0]         off_inc, off_adv, off_cur;
    logic [RW-1:0]         rem_inc, off_rem_adv, off_rem_cur;
    logic [2:0]            off_idx_adv, off_idx_cur;
    logic [XW-1:0]         x_cur, x_nxt;
    logic [2:0]            idx_cur, idx_nxt;
    logic [RW-1:0]         rem_cur, rem_nxt;
    logic [HW-1:0]         h_nxt;
    logic [VW-1:0]         v_nxt;
    logic                  de_n, hs_n, vs_n;
    logic [3*PIX_SZ-1:0]   rgb_n;

    always_comb begin
        frame_first = (h_pos == '0) && (v_pos == '0);
        mode_cur    = frame_first ? mode_i : mode_q;
        solid_cur   = frame_first ? solid_rgb_i : solid_q;

        // Offset advance assumes SCROLL_STEP <= BAR_W.
        off_inc     = off_q + X_STEP;
        rem_inc     = off_rem_q + R_STEP;
        off_adv     = off_inc;
        off_idx_adv = off_idx_q;
        off_rem_adv = rem_inc;
        if (off_inc >= X_ACT) begin
            off_adv     = off_inc - X_ACT;
            off_idx_adv = 3'd0;
            off_rem_adv = RW'(off_inc - X_ACT);
        end else if (rem_inc >= R_BAR) begin
            off_rem_adv = rem_inc - R_BAR;
            off_idx_adv = (off_idx_q == 3'd7) ? 3'd7 : off_idx_q + 3'd1;
        end

        off_cur     = off_q;
        off_idx_cur = off_idx_q;
        off_rem_cur = off_rem_q;
        if (frame_first && scroll_en_i) begin
            off_cur     = off_adv;
            off_idx_cur = off_idx_adv;
            off_rem_cur = off_rem_adv;
        end
    end

    always_comb begin
        x_cur   = x_q;
        idx_cur = idx_q;
        rem_cur = rem_q;
        if (h_pos == '0) begin
            x_cur   = off_cur;
            idx_cur = off_idx_cur;
            rem_cur = off_rem_cur;
        end

        x_nxt   = x_cur + XW'(1);
        idx_nxt = idx_cur;
        rem_nxt = rem_cur + RW'(1);
        if (x_cur == X_LAST) begin
            x_nxt   = '0;
            idx_nxt = 3'd0;
            rem_nxt = '0;
        end else if (rem_cur == R_LAST) begin
            rem_nxt = '0;
            idx_nxt = (idx_cur == 3'd7) ? 3'd7 : idx_cur + 3'd1;
        end
    end

    always_comb begin
        h_nxt = h_pos + HW'(1);
        v_nxt = v_pos;
        if (h_pos == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_pos == V_LAST) ? '0 : v_pos + VW'(1);
        end
    end

    always_comb begin
        de_n = (h_pos <= H_ACT_LAST) && (v_pos <= V_ACT_LAST);
        hs_n = (h_pos >= HS_FIRST && h_pos <= HS_LAST) ? HS_ON : ~HS_ON;
        vs_n = (v_pos >= VS_FIRST && v_pos <= VS_LAST) ? VS_ON : ~VS_ON;
        rgb_n = '0;
        case (mode_cur)
            2'd0:    rgb_n = {{PIX_SZ{~idx_cur[1]}}, {PIX_SZ{~idx_cur[2]}}, {PIX_SZ{~idx_cur[0]}}};
            2'd1:    rgb_n = (h_pos[CHK_LOG2] ^ v_pos[CHK_LOG2]) ? '0 : '1;
            2'd2:    rgb_n = {3{PIX_SZ'(h_pos)}};
            default: rgb_n = solid_cur;
        endcase
        if (!de_n) rgb_n = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_pos         <= '0;
            v_pos         <= '0;
            mode_q        <= '0;
            solid_q       <= '0;
            off_q         <= '0;
            off_idx_q     <= '0;
            off_rem_q     <= '0;
            x_q           <= '0;
            idx_q         <= '0;
            rem_q         <= '0;
            hcount_o      <= '0;
            vcount_o      <= '0;
            de_o          <= 1'b0;
            hsync_o       <= ~HS_ON;
            vsync_o       <= ~VS_ON;
            frame_start_o <= 1'b0;
            r_o           <= '0;
            g_o           <= '0;
            b_o           <= '0;
        end else begin
            h_pos         <= h_nxt;
            v_pos         <= v_nxt;
            mode_q        <= mode_cur;
            solid_q       <= solid_cur;
            off_q         <= off_cur;
            off_idx_q     <= off_idx_cur;
            off_rem_q     <= off_rem_cur;
            x_q           <= x_nxt;
            idx_q         <= idx_nxt;
            rem_q         <= rem_nxt;
            hcount_o      <= h_pos;
            vcount_o      <= v_pos;
            de_o          <= de_n;
            hsync_o       <= hs_n;
            vsync_o       <= vs_n;
            frame_start_o <= frame_first;
            {r_o, g_o, b_o} <= rgb_n;
        end
    end
endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_ACTIVE 640, visible pixels per line
- H_FP 16, H_SYNC 96, H_BP 48, horizontal porch and sync widths in pixels
- V_ACTIVE 480, visible lines
- V_FP 10, V_SYNC 2, V_BP 33, vertical porch and sync widths in lines
- HS_POL 0 and VS_POL 0, asserted level of hsync_o and vsync_o
- PIX_SZ 8, bits per colour channel
- CHK_LOG2 5, checker square side is 2^CHK_LOG2 pixels
- SCROLL_STEP 1, pixels of bar shift per frame

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, pixel clock; the only clock
- rst_i, in, 1, synchronous active-high reset
- mode_i, in, 2, pattern select: 0 bars, 1 checker, 2 gradient, 3 solid
- scroll_en_i, in, 1, enable horizontal scrolling of the bars
- solid_rgb_i, in, 3*PIX_SZ, solid colour as {r,g,b}
- hcount_o, out, clog2(H_TOTAL), horizontal position
- vcount_o, out, clog2(V_TOTAL), vertical position
- de_o, out, 1, active-area flag
- hsync_o, out, 1, horizontal sync
- vsync_o, out, 1, vertical sync
- frame_start_o, out, 1, first-pixel-of-frame pulse
- r_o, g_o, b_o, out, PIX_SZ each, pixel colour

Function
REQ-003 Totals SHALL be H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP and V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP.
REQ-004 Every output SHALL be registered, and in any cycle all outputs SHALL describe the position (hcount_o, vcount_o).
REQ-005 Horizontal position SHALL advance by 1 per cycle and wrap from H_TOTAL-1 to 0; vertical position SHALL advance only on that horizontal wrap and wrap from V_TOTAL-1 to 0.
REQ-006 de_o SHALL be 1 exactly when hcount_o < H_ACTIVE and vcount_o < V_ACTIVE.
REQ-007 hsync_o SHALL equal HS_POL for hcount_o in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and ~HS_POL otherwise.
REQ-008 vsync_o SHALL follow REQ-007 on vcount_o with the V_* parameters and VS_POL, and SHALL be independent of hcount_o.
REQ-009 frame_start_o SHALL be 1 for exactly one cycle per frame, when (hcount_o, vcount_o) = (0,0).
REQ-010 mode_i, scroll_en_i and solid_rgb_i SHALL be sampled only when computing position (0,0); the sampled values SHALL govern the whole frame, and mid-frame changes SHALL have no effect until the next frame.
REQ-011 r_o, g_o and b_o SHALL be 0 whenever de_o = 0.
REQ-012 Mode 0 (bars): BAR_W = H_ACTIVE/8 (integer division); x = (hcount_o + offset) mod H_ACTIVE; bar index = min(x/BAR_W, 7).
- Bar colours in index order: white, yellow, cyan, green, magenta, red, blue, black.
- Each channel is all-ones or 0.
REQ-013 Mode 1 (checker): white when hcount_o[CHK_LOG2] XOR vcount_o[CHK_LOG2] = 0, black otherwise.
REQ-014 Mode 2 (gradient): r_o = g_o = b_o = hcount_o[PIX_SZ-1:0], zero-extended if hcount_o is narrower than PIX_SZ.
REQ-015 Mode 3 (solid): {r_o, g_o, b_o} SHALL equal the sampled solid_rgb_i.
REQ-016 offset SHALL be a register in [0, H_ACTIVE-1].
- When sampled scroll_en = 1 at a frame start, offset becomes (offset + SCROLL_STEP) mod H_ACTIVE for that frame.
- When sampled scroll_en = 0, offset holds.
- offset affects mode 0 only.
REQ-017 Division or modulo by a non-power-of-2 SHALL NOT be synthesised per pixel; bar tracking SHALL be done with incremental counters.

Reset
REQ-018 While rst_i = 1 at a rising edge:
- internal position, offset and sampled mode SHALL become 0;
- hcount_o, vcount_o, de_o, frame_start_o and the colour outputs SHALL become 0;
- hsync_o SHALL become ~HS_POL and vsync_o SHALL become ~VS_POL.
REQ-019 On the first rising edge with rst_i = 0, outputs SHALL show position (0,0) with frame_start_o = 1 and de_o = 1.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no partial-line completion.

Verification
REQ-021 The bench SHALL cover these directed scenarios with default parameters:
- Release reset, run 2 frames -> frame_start_o pulses exactly every 420000 cycles; de_o is high for 307200 cycles per frame; hsync_o is 0 for hcount 656..751; vsync_o is 0 for vcount 490..491.
- Mode 0, scroll off -> on line 0, pixels 0..79 are FFFFFF, 80..159 are FFFF00, and 560..639 are 000000; pixel 640 is 000000 with de_o = 0.
- Mode 0, scroll on for 3 frames -> offset = 3 in the third frame; pixel 77 is FFFF00 and pixel 637 is FFFFFF.
- Switch mode_i from 0 to 3 with solid_rgb_i = 123456 at line 100 -> the rest of the frame stays bars; the next frame is all 123456 in the active area.
- Mode 1 -> (0,0) is white, (32,0) black, (32,32) white; mode 2 -> pixel 300 = 2C on all channels.
- Assert rst_i for 1 cycle at (400,200) -> the next cycle outputs are all 0 with syncs inactive; the cycle after shows (0,0) with frame_start_o = 1.
